encoder_flush_sequencer: RTL and testbench

ENCODER_FLUSH_SEQUENCER -- requirements
Module: encoder_flush_sequencer

---
 rtl/encoder_flush_sequencer.sv | 87 ++++++++
 tb/tb_encoder_flush_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/encoder_flush_sequencer.sv
// encoder_flush_sequencer: frame start/flush control for the arithmetic encoder's final-bits and carry stages
module encoder_flush_sequencer #(
  parameter int WARMUP_CYCLES = 2,
  parameter int DRAIN_CYCLES  = 3,
  parameter int CNT_WIDTH     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_last,
  output logic in_ready,
  output logic flag_first,
  output logic final_flag_2_3,
  output logic final_flag,
  output logic carry_en,
  output logic busy,
  output logic done,
  output logic protocol_error
);
  typedef enum logic [2:0] {WARMUP, IDLE, RUN, LATCH, FLUSH, DRAIN, DONE} state_t;
  localparam logic [CNT_WIDTH-1:0] WARM_LD  = CNT_WIDTH'(WARMUP_CYCLES);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LD = CNT_WIDTH'(DRAIN_CYCLES);
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n, cnt_dec;
  logic accept;
  logic in_ready_n, flag_first_n, final_flag_2_3_n, final_flag_n, carry_en_n, busy_n, done_n, protocol_error_n;
  assign accept  = in_valid & in_ready;
  assign cnt_dec = (cnt == '0) ? '0 : cnt - CNT_WIDTH'(1);
  // next state, counter and the values every output register takes on entering that state
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      WARMUP: begin
        cnt_n   = cnt_dec;
        state_n = (cnt == '0) ? IDLE : WARMUP;
      end
      IDLE:    state_n = accept ? (in_last ? LATCH : RUN) : IDLE;
      RUN:     state_n = (accept && in_last) ? LATCH : RUN;
      LATCH:   state_n = FLUSH;
      FLUSH: begin
        cnt_n   = DRAIN_LD;
        state_n = (DRAIN_LD == '0) ? DONE : DRAIN;
      end
      DRAIN: begin
        cnt_n   = cnt_dec;
        state_n = (cnt_dec == '0) ? DONE : DRAIN;
      end
      DONE:    state_n = IDLE;
      default: state_n = WARMUP;
    endcase
    in_ready_n       = (state_n == IDLE) || (state_n == RUN);
    flag_first_n     = (state == IDLE) && accept;
    final_flag_2_3_n = state_n == LATCH;
    final_flag_n     = state_n == FLUSH;
    carry_en_n       = state_n != WARMUP;
    busy_n           = (state_n != WARMUP) && (state_n != IDLE);
    done_n           = state_n == DONE;
    protocol_error_n = in_valid && !in_ready;
  end
  // state, counter and registered outputs; reset wins over any in-flight frame
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= WARMUP;
      cnt            <= WARM_LD;
      in_ready       <= 1'b0;
      flag_first     <= 1'b0;
      final_flag_2_3 <= 1'b0;
      final_flag     <= 1'b0;
      carry_en       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      in_ready       <= in_ready_n;
      flag_first     <= flag_first_n;
      final_flag_2_3 <= final_flag_2_3_n;
      final_flag     <= final_flag_n;
      carry_en       <= carry_en_n;
      busy           <= busy_n;
      done           <= done_n;
      protocol_error <= protocol_error_n;
    end
  end
endmodule

// File: tb/tb_encoder_flush_sequencer.sv
// tb_encoder_flush_sequencer: scoreboarded pulse timing plus level checks for default and zero-count builds
module tb_encoder_flush_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic ra, va, la, rb, vb, lb;
  logic a_rdy, a_ff, a_f23, a_fin, a_ce, a_busy, a_done, a_perr;
  logic b_rdy, b_ff, b_f23, b_fin, b_ce, b_busy, b_done, b_perr;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int c;
  typedef struct {int c; bit d; logic [4:0] v;} ev_t;
  ev_t q[$];
  encoder_flush_sequencer dut_a (
    .clk(clk), .reset(ra), .in_valid(va), .in_last(la), .in_ready(a_rdy),
    .flag_first(a_ff), .final_flag_2_3(a_f23), .final_flag(a_fin), .carry_en(a_ce),
    .busy(a_busy), .done(a_done), .protocol_error(a_perr)
  );
  encoder_flush_sequencer #(.WARMUP_CYCLES(0), .DRAIN_CYCLES(0), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(rb), .in_valid(vb), .in_last(lb), .in_ready(b_rdy),
    .flag_first(b_ff), .final_flag_2_3(b_f23), .final_flag(b_fin), .carry_en(b_ce),
    .busy(b_busy), .done(b_done), .protocol_error(b_perr)
  );
  wire [4:0] pa = {a_ff, a_f23, a_fin, a_done, a_perr};
  wire [4:0] pb = {b_ff, b_f23, b_fin, b_done, b_perr};
  wire [7:0] oa = {a_rdy, a_ff, a_f23, a_fin, a_ce, a_busy, a_done, a_perr};
  wire [7:0] ob = {b_rdy, b_ff, b_f23, b_fin, b_ce, b_busy, b_done, b_perr};
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int n);
    repeat (n) tick();
  endtask
  task automatic push(int ec, bit d, logic [4:0] v);
    ev_t e;
    e.c = ec;
    e.d = d;
    e.v = v;
    q.push_back(e);
  endtask
  task automatic sym(bit d, bit last);
    if (d) begin
      vb = 1'b1;
      lb = last;
    end else begin
      va = 1'b1;
      la = last;
    end
    tick();
    va = 1'b0;
    la = 1'b0;
    vb = 1'b0;
    lb = 1'b0;
  endtask
  task automatic chk(string n, logic [7:0] a, logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d got %h want %h", n, cyc, a, e);
    end
  endtask
  task automatic match(bit d, logic [4:0] v);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL pulse dut%0d cycle %0d got %b, no pulse expected", d, cyc, v);
    end else begin
      e = q.pop_front();
      if (e.c != cyc || e.d != d || e.v !== v) begin
        errors++;
        $display("FAIL pulse dut%0d cycle %0d got %b want dut%0d cycle %0d %b", d, cyc, v, e.d, e.c, e.v);
      end
    end
  endtask
  // monitor: every pulse on either DUT must match the next expected event
  always @(negedge clk) begin
    if (|pa === 1'b1) match(1'b0, pa);
    if (|pb === 1'b1) match(1'b1, pb);
  end
  initial begin
    ra = 1'b1; rb = 1'b1; va = 1'b0; la = 1'b0; vb = 1'b0; lb = 1'b0;
    idle(3);
    chk("reset_a", oa, 8'h00);
    chk("reset_b", ob, 8'h00);
    ra = 1'b0;
    tick();
    chk("warm1_ce", 8'(a_ce), 8'd0);
    tick();
    chk("warm2_ce", 8'(a_ce), 8'd0);
    chk("warm2_rdy", 8'(a_rdy), 8'd0);
    tick();
    chk("idle_ce", 8'(a_ce), 8'd1);
    chk("idle_rdy", 8'(a_rdy), 8'd1);
    chk("idle_busy", 8'(a_busy), 8'd0);
    c = cyc;
    push(c + 1, 1'b0, 5'b10000);
    sym(1'b0, 1'b0);
    tick();
    chk("run_stall_rdy", 8'(a_rdy), 8'd1);
    chk("run_stall_busy", 8'(a_busy), 8'd1);
    sym(1'b0, 1'b0);
    c = cyc;
    push(c + 1, 1'b0, 5'b01000);
    push(c + 2, 1'b0, 5'b00100);
    push(c + 6, 1'b0, 5'b00010);
    sym(1'b0, 1'b1);
    chk("latch_rdy", 8'(a_rdy), 8'd0);
    chk("latch_busy", 8'(a_busy), 8'd1);
    idle(5);
    chk("done_rdy", 8'(a_rdy), 8'd0);
    tick();
    chk("post_done_rdy", 8'(a_rdy), 8'd1);
    chk("post_done_busy", 8'(a_busy), 8'd0);
    c = cyc;
    push(c + 1, 1'b0, 5'b11000);
    push(c + 2, 1'b0, 5'b00100);
    push(c + 6, 1'b0, 5'b00010);
    sym(1'b0, 1'b1);
    idle(6);
    chk("single_end_rdy", 8'(a_rdy), 8'd1);
    la = 1'b1;
    tick();
    la = 1'b0;
    chk("last_only_busy", 8'(a_busy), 8'd0);
    chk("last_only_rdy", 8'(a_rdy), 8'd1);
    c = cyc;
    push(c + 1, 1'b0, 5'b10000);
    push(c + 2, 1'b0, 5'b01000);
    push(c + 3, 1'b0, 5'b00100);
    push(c + 5, 1'b0, 5'b00001);
    push(c + 7, 1'b0, 5'b00010);
    sym(1'b0, 1'b0);
    sym(1'b0, 1'b1);
    idle(2);
    va = 1'b1;
    tick();
    va = 1'b0;
    chk("drain_perr_rdy", 8'(a_rdy), 8'd0);
    chk("drain_perr_busy", 8'(a_busy), 8'd1);
    idle(3);
    chk("perr_end_rdy", 8'(a_rdy), 8'd1);
    c = cyc;
    push(c + 1, 1'b0, 5'b11000);
    push(c + 2, 1'b0, 5'b00100);
    sym(1'b0, 1'b1);
    tick();
    ra = 1'b1;
    tick();
    chk("flush_reset", oa, 8'h00);
    ra = 1'b0;
    tick();
    chk("rewarm1_ce", 8'(a_ce), 8'd0);
    tick();
    chk("rewarm2_ce", 8'(a_ce), 8'd0);
    tick();
    chk("rewarm_ce", 8'(a_ce), 8'd1);
    chk("rewarm_rdy", 8'(a_rdy), 8'd1);
    idle(6);
    rb = 1'b0;
    tick();
    chk("b_idle_ce", 8'(b_ce), 8'd1);
    chk("b_idle_rdy", 8'(b_rdy), 8'd1);
    chk("b_idle_busy", 8'(b_busy), 8'd0);
    c = cyc;
    push(c + 1, 1'b1, 5'b11000);
    push(c + 2, 1'b1, 5'b00100);
    push(c + 3, 1'b1, 5'b00010);
    sym(1'b1, 1'b1);
    idle(3);
    chk("b_after_done_rdy", 8'(b_rdy), 8'd1);
    c = cyc;
    push(c + 1, 1'b1, 5'b10000);
    push(c + 2, 1'b1, 5'b01000);
    push(c + 3, 1'b1, 5'b00100);
    push(c + 4, 1'b1, 5'b00010);
    sym(1'b1, 1'b0);
    sym(1'b1, 1'b1);
    idle(4);
    chk("b_end_rdy", 8'(b_rdy), 8'd1);
    idle(2);
    chk("missing_pulses", 8'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
